// File: rtl/io_port_pkg.sv
// Shared sizing constants for the processor I/O port blocks.
package io_port_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

endpackage : io_port_pkg

// File: rtl/port_fifo_mem.sv
// DEPTH x DATA_W register file: synchronous write, asynchronous read.
module port_fifo_mem #(
  parameter int unsigned DATA_W = io_port_pkg::DATA_W,
  parameter int unsigned DEPTH  = io_port_pkg::DEPTH,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : port_fifo_mem

// File: rtl/output_port_fifo.sv
// Output port buffer between processor OUT instructions and an external
// valid/ready sink. Pointer, occupancy and overflow state live here; the
// word storage is in port_fifo_mem.
module output_port_fifo #(
  parameter int unsigned DATA_W = io_port_pkg::DATA_W,
  parameter int unsigned DEPTH  = io_port_pkg::DEPTH
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Out_Write,
  input  logic [DATA_W-1:0]        Output_Data,
  output logic [DATA_W-1:0]        Port_Data,
  output logic                     Port_Valid,
  input  logic                     Port_Ready,
  output logic                     Full,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow,
  input  logic                     Overflow_Clear
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;
  logic [DATA_W-1:0] head_data;
  logic              pop;
  logic              push;
  logic              drop;

  // Status flags come straight from registered occupancy, so Port_Valid has
  // no combinational dependence on any input.
  assign Port_Valid = (count_q != '0);
  assign Full       = (count_q == CNT_W'(DEPTH));
  assign Count      = count_q;
  assign Overflow   = overflow_q;
  assign Port_Data  = Port_Valid ? head_data : '0;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign pop  = Port_Valid & Port_Ready;
  assign push = Out_Write & (~Full | pop);
  assign drop = Out_Write & ~push;

  // Pointers, occupancy and sticky overflow; reset beats every other update.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (Overflow_Clear) begin
        overflow_q <= 1'b0;
      end
    end
  end

  port_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk   (Clock),
    .we    (push & ~Reset),
    .waddr (wr_ptr),
    .wdata (Output_Data),
    .raddr (rd_ptr),
    .rdata (head_data)
  );

endmodule : output_port_fifo

// File: tb/tb_output_port_fifo.sv
// Scoreboard bench for output_port_fifo: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_output_port_fifo;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 3;

  logic              Clock = 1'b0;
  logic              Reset = 1'b0;
  logic              Out_Write = 1'b0;
  logic [DATA_W-1:0] Output_Data = '0;
  logic [DATA_W-1:0] Port_Data;
  logic              Port_Valid;
  logic              Port_Ready = 1'b0;
  logic              Full;
  logic [CNT_W-1:0]  Count;
  logic              Overflow;
  logic              Overflow_Clear = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;
  int max_count = 0;
  bit track_max = 1'b0;

  logic [DATA_W-1:0] mdl_q[$];
  logic [DATA_W-1:0] exp_q[$];
  bit                mdl_ovf = 1'b0;

  output_port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Out_Write      (Out_Write),
    .Output_Data    (Output_Data),
    .Port_Data      (Port_Data),
    .Port_Valid     (Port_Valid),
    .Port_Ready     (Port_Ready),
    .Full           (Full),
    .Count          (Count),
    .Overflow       (Overflow),
    .Overflow_Clear (Overflow_Clear)
  );

  always #5 Clock = ~Clock;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: FIFO behaviour expressed as queue operations.
  always @(posedge Clock) begin
    bit do_pop, do_push;
    if (Reset) begin
      mdl_q.delete();
      exp_q.delete();
      mdl_ovf = 1'b0;
    end else begin
      do_pop  = (mdl_q.size() != 0) && Port_Ready;
      do_push = Out_Write && ((mdl_q.size() < DEPTH) || do_pop);
      if (do_pop) void'(mdl_q.pop_front());
      if (do_push) begin
        mdl_q.push_back(Output_Data);
        exp_q.push_back(Output_Data);
      end
      if (Out_Write && !do_push) mdl_ovf = 1'b1;
      else if (Overflow_Clear)   mdl_ovf = 1'b0;
    end
  end

  // Monitor: compares status every cycle and scoreboards each delivered word.
  always @(negedge Clock) begin
    static bit                hold_prev = 1'b0;
    static logic [DATA_W-1:0] data_prev = '0;
    if (checking) begin
      chk("count", 32'(Count), 32'(mdl_q.size()));
      chk("valid", 32'(Port_Valid), 32'(mdl_q.size() != 0));
      chk("full", 32'(Full), 32'(mdl_q.size() == DEPTH));
      chk("overflow", 32'(Overflow), 32'(mdl_ovf));
      chk("port_data", 32'(Port_Data), (mdl_q.size() != 0) ? 32'(mdl_q[0]) : 32'h0);
      if (hold_prev && Port_Valid) chk("data_stable", 32'(Port_Data), 32'(data_prev));
      if (track_max && int'(Count) > max_count) max_count = int'(Count);
      if (Port_Valid && Port_Ready && !Reset) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(Port_Data), 32'hFFFF_FFFF);
        end else begin
          chk("delivered_word", 32'(Port_Data), 32'(exp_q.pop_front()));
        end
      end
      hold_prev = Port_Valid && !Port_Ready && !Reset;
      data_prev = Port_Data;
    end
  end

  task automatic step(input logic wr, input logic [DATA_W-1:0] d, input logic rdy,
                      input logic clr, input logic rst);
    Out_Write      = wr;
    Output_Data    = d;
    Port_Ready     = rdy;
    Overflow_Clear = clr;
    Reset          = rst;
    @(posedge Clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #2;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checking = 1'b1;
    chk("reset_valid", 32'(Port_Valid), 32'h0);
    chk("reset_data", 32'(Port_Data), 32'h0);
    chk("reset_count", 32'(Count), 32'h0);
    chk("reset_full", 32'(Full), 32'h0);

    // Single word latency
    step(1'b1, 16'h0906, 1'b0, 1'b0, 1'b0);
    chk("first_valid", 32'(Port_Valid), 32'h1);
    chk("first_data", 32'(Port_Data), 32'h0906);
    chk("first_count", 32'(Count), 32'h1);
    drain();

    // Fill then drain in order
    for (int i = 1; i <= 4; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b0, 1'b0);
    chk("fill_full", 32'(Full), 32'h1);
    chk("fill_count", 32'(Count), 32'h4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", 32'(Port_Data), 32'(i));
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    chk("drained_valid", 32'(Port_Valid), 32'h0);
    chk("drained_data", 32'(Port_Data), 32'h0);

    // Overflow on a dropped write, then clear; set beats clear
    for (int i = 1; i <= 4; i++) step(1'b1, DATA_W'(16'h20 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 32'(Overflow), 32'h1);
    chk("ovf_count", 32'(Count), 32'h4);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("ovf_clear", 32'(Overflow), 32'h0);
    step(1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0);
    chk("ovf_set_wins", 32'(Overflow), 32'h1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("head_after_drop", 32'(Port_Data), 32'h21);
    drain();

    // Push and pop together while full
    for (int i = 1; i <= 4; i++) step(1'b1, DATA_W'(16'h10 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h00AA, 1'b1, 1'b0, 1'b0);
    chk("full_pp_count", 32'(Count), 32'h4);
    chk("full_pp_ovf", 32'(Overflow), 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("fifth_word", 32'(Port_Data), 32'h00AA);
    chk("fifth_count", 32'(Count), 32'h1);
    drain();

    // Streaming across pointer wrap
    max_count = 0;
    track_max = 1'b1;
    for (int i = 1; i <= 10; i++) step(1'b1, DATA_W'(i), 1'b1, 1'b0, 1'b0);
    drain();
    track_max = 1'b0;
    chk("stream_max_count", 32'(max_count), 32'h1);
    chk("stream_sb_empty", 32'(exp_q.size()), 32'h0);

    // Reset discards buffered words
    for (int i = 1; i <= 3; i++) step(1'b1, DATA_W'(16'h30 + i), 1'b0, 1'b0, 1'b0);
    chk("pre_reset_count", 32'(Count), 32'h3);
    step(1'b1, 16'h5555, 1'b1, 1'b1, 1'b1);
    chk("post_reset_count", 32'(Count), 32'h0);
    chk("post_reset_valid", 32'(Port_Valid), 32'h0);
    chk("post_reset_ovf", 32'(Overflow), 32'h0);
    step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    chk("after_reset_head", 32'(Port_Data), 32'h1234);
    drain();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 99) < 55), DATA_W'($urandom),
           1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 8),
           1'($urandom_range(0, 99) < 2));
    end
    drain();
    idle(2);
    chk("final_sb_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_output_port_fifo

// File: doc/output_port_fifo.md
OUTPUT_PORT_FIFO -- requirements
Module: output_port_fifo

Interface
REQ-001 Parameter DATA_W, default 16, width of processor output word and port data.
REQ-002 Parameter DEPTH, default 4, number of buffered words; power of two, at least 2.
REQ-003 Clock  input  1  single system clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Out_Write  input  1  processor OUT-instruction strobe, one cycle per word.
REQ-006 Output_Data  input  DATA_W  processor output word, sampled when Out_Write=1.
REQ-007 Port_Data  output  DATA_W  word presented to the external sink.
REQ-008 Port_Valid  output  1  Port_Data holds an unconsumed word.
REQ-009 Port_Ready  input  1  sink accepts Port_Data this cycle.
REQ-010 Full  output  1  Count equals DEPTH.
REQ-011 Count  output  log2(DEPTH)+1  number of stored words, 0..DEPTH.
REQ-012 Overflow  output  1  sticky flag: a write was dropped.
REQ-013 Overflow_Clear  input  1  clears Overflow.

Function
REQ-014 Words are delivered to the sink in write order (FIFO), never duplicated, never reordered.
REQ-015 Push occurs when Out_Write=1 and (Full=0, or a pop occurs in the same cycle).
REQ-016 Pop occurs when Port_Valid=1 and Port_Ready=1.
REQ-017 Port_Valid = (Count != 0); Port_Data = oldest stored word when Port_Valid=1, 16'h0000 (all zeros) when Port_Valid=0.
REQ-018 Latency: a word pushed at edge N, into an empty FIFO, appears on Port_Data with Port_Valid=1 in the cycle following edge N.
REQ-019 No combinational path from Out_Write or Output_Data to Port_Data or Port_Valid; no path from Port_Ready to Port_Valid.
REQ-020 Write and read pointers each log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-021 Count: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
REQ-022 Simultaneous push and pop when empty is impossible (Port_Valid=0); the push alone takes effect.
REQ-023 Simultaneous push and pop when full: both take effect, Count stays DEPTH, Overflow unchanged.
REQ-024 Out_Write=1 while Full=1 without a pop: word dropped, storage and pointers unchanged, Overflow set at that edge.
REQ-025 Port_Ready=1 while empty: no effect.
REQ-026 Overflow set and Overflow_Clear in the same cycle: set wins.
REQ-027 Port_Data must remain stable while Port_Valid=1 and Port_Ready=0.

Reset
REQ-028 Reset=1 at a rising edge: pointers=0, Count=0, Overflow=0. Port_Valid=0, Port_Data=0 and Full=0 from the following cycle.
REQ-029 Reset takes priority over push, pop and Overflow_Clear in the same cycle. Words buffered mid-operation are discarded.
REQ-030 Storage array contents need no reset.

Structure
REQ-031 Package io_port_pkg holds DATA_W, DEPTH and derived PTR_W/CNT_W constants, shared with the future input-port block.
REQ-032 One sub-module, port_fifo_mem: DEPTH x DATA_W register array with a synchronous write port and an asynchronous read port. Pointer, count and flag logic stays in output_port_fifo.

Verification
REQ-033 Reset, then Out_Write=1 with Output_Data=16'h0906 for one cycle, Port_Ready=0 -> next cycle Port_Valid=1, Port_Data=16'h0906, Count=1.
REQ-034 Push 16'h0001..16'h0004 with Port_Ready=0 -> Full=1, Count=4. Then Port_Ready=1 -> data 0001,0002,0003,0004 on consecutive cycles, then Port_Valid=0, Port_Data=0.
REQ-035 Full, push 16'hBEEF with Port_Ready=0 -> Overflow=1, Count=4, 16'hBEEF never delivered. Overflow_Clear=1 for one cycle -> Overflow=0.
REQ-036 Full, Out_Write=1 with 16'h00AA and Port_Ready=1 in the same cycle -> Count stays 4, Overflow=0, 16'h00AA delivered fifth.
REQ-037 Continuous push and pop for 10 cycles (values 1..10), covering pointer wrap -> output sequence 1..10, Count never exceeds 1.
REQ-038 Reset asserted with Count=3 -> next cycle Count=0, Port_Valid=0, Overflow=0. A subsequent push of 16'h1234 is delivered first.
